// File: rtl/arf_mem_sequencer.sv
// Sequences 16-bit little-endian word accesses over an 8-bit memory bus, using the
// ARF (PC/AR/SP) as the address source and stepping the selected pointer per byte.
module arf_mem_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] wr_data_i,
  output logic              rsp_valid_o,
  output logic [ADDR_W-1:0] rsp_data_o,
  output logic [2:0]        arf_fun_sel_o,
  output logic [2:0]        arf_reg_sel_o,
  output logic [1:0]        arf_outd_sel_o,
  input  logic [ADDR_W-1:0] arf_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [BYTE_W-1:0] mem_data_out_o,
  input  logic [BYTE_W-1:0] mem_data_in_i
);

  typedef enum logic [2:0] {StIdle, StPdec, StB0, StB1, StRsp} state_e;

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPush  = 2'b10;

  localparam logic [2:0] FunDec  = 3'b000;
  localparam logic [2:0] FunInc  = 3'b001;
  localparam logic [2:0] FunLoad = 3'b010;

  // RegSel is {PC, AR, SP}, active-low enables.
  localparam logic [2:0] SelPc   = 3'b011;
  localparam logic [2:0] SelAr   = 3'b101;
  localparam logic [2:0] SelSp   = 3'b110;
  localparam logic [2:0] SelNone = 3'b111;

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   wdata_q;
  logic [BYTE_W-1:0]   lo_q;
  logic [ADDR_W-1:0]   rsp_data_q;
  logic [2:0]          ptr_sel;
  logic [1:0]          ptr_outd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpFetch;
      wdata_q    <= '0;
      lo_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid_i) begin
        op_q    <= req_op_i;
        wdata_q <= wr_data_i;
      end
      if (state_q == StB0) lo_q <= mem_data_in_i;
      // Update the visible word only once the whole access has completed.
      if (state_q == StB1) begin
        rsp_data_q <= (op_q == OpPush) ? wdata_q : {mem_data_in_i, lo_q};
      end
    end
  end

  always_comb begin
    unique case (op_q)
      OpFetch: begin ptr_sel = SelPc; ptr_outd = 2'b00; end
      OpRead:  begin ptr_sel = SelAr; ptr_outd = 2'b10; end
      default: begin ptr_sel = SelSp; ptr_outd = 2'b11; end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    arf_fun_sel_o  = FunLoad;
    arf_reg_sel_o  = SelNone;
    arf_outd_sel_o = 2'b00;
    mem_en_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_data_out_o = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = (req_op_i == OpPush) ? StPdec : StB0;
      end
      StPdec: begin
        arf_outd_sel_o = ptr_outd;
        arf_reg_sel_o  = SelSp;
        arf_fun_sel_o  = FunDec;
        state_d        = StB0;
      end
      StB0: begin
        arf_outd_sel_o = ptr_outd;
        arf_reg_sel_o  = ptr_sel;
        mem_en_o       = 1'b1;
        if (op_q == OpPush) begin
          mem_wr_o       = 1'b1;
          mem_data_out_o = wdata_q[ADDR_W-1:BYTE_W];
          arf_fun_sel_o  = FunDec;
        end else begin
          arf_fun_sel_o  = FunInc;
        end
        state_d = StB1;
      end
      StB1: begin
        arf_outd_sel_o = ptr_outd;
        mem_en_o       = 1'b1;
        if (op_q == OpPush) begin
          mem_wr_o       = 1'b1;
          mem_data_out_o = wdata_q[BYTE_W-1:0];
        end else begin
          arf_reg_sel_o  = ptr_sel;
          // READ walks back so AR is left where it started.
          arf_fun_sel_o  = (op_q == OpRead) ? FunDec : FunInc;
        end
        state_d = StRsp;
      end
      StRsp: begin
        rsp_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_data_o = rsp_data_q;
  assign mem_addr_o = arf_addr_i;

endmodule

// File: tb/tb_arf_mem_sequencer.sv
// Randomised scoreboard bench for arf_mem_sequencer with a behavioural ARF/memory
// environment and a word-level reference model.
module tb_arf_mem_sequencer;

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPush  = 2'b10;
  localparam logic [1:0] OpPop   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, mem_en, mem_wr;
  logic [1:0]  req_op, outd_sel;
  logic [15:0] req_wdata, rsp_data, arf_addr, mem_addr;
  logic [2:0]  fun_sel, reg_sel;
  logic [7:0]  mem_data_out, mem_data_in;

  always #5 clk = ~clk;

  arf_mem_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .wr_data_i      (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .arf_fun_sel_o  (fun_sel),
    .arf_reg_sel_o  (reg_sel),
    .arf_outd_sel_o (outd_sel),
    .arf_addr_i     (arf_addr),
    .mem_addr_o     (mem_addr),
    .mem_en_o       (mem_en),
    .mem_wr_o       (mem_wr),
    .mem_data_out_o (mem_data_out),
    .mem_data_in_i  (mem_data_in)
  );

  // Environment: ARF registers and byte memory.
  logic [15:0] pc_e, ar_e, sp_e;
  logic [7:0]  mem_e [65536];
  logic        ld_en = 1'b0, poke_en = 1'b0;
  logic [15:0] ld_pc, ld_ar, ld_sp, poke_addr;
  logic [7:0]  poke_data;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'hA5;
  endfunction

  function automatic logic [15:0] step(input logic [15:0] v, input logic [2:0] f);
    if (f == 3'b000) return v - 16'd1;
    if (f == 3'b001) return v + 16'd1;
    return v;
  endfunction

  always_comb arf_addr = (outd_sel == 2'b10) ? ar_e : (outd_sel == 2'b11) ? sp_e : pc_e;
  assign mem_data_in = mem_e[mem_addr];

  initial begin
    for (int i = 0; i < 65536; i++) mem_e[i] = init_byte(16'(i));
    pc_e = '0; ar_e = '0; sp_e = '0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_wr) mem_e[mem_addr] <= mem_data_out;
      if (poke_en) mem_e[poke_addr] <= poke_data;
      if (ld_en) begin
        pc_e <= ld_pc; ar_e <= ld_ar; sp_e <= ld_sp;
      end else begin
        if (!reg_sel[2]) pc_e <= step(pc_e, fun_sel);
        if (!reg_sel[1]) ar_e <= step(ar_e, fun_sel);
        if (!reg_sel[0]) sp_e <= step(sp_e, fun_sel);
      end
    end
  end

  // Reference model: word-level view of registers and memory.
  typedef struct {
    logic [15:0] data, pc, ar, sp;
    int          acc, lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [logic [15:0]];
  logic [15:0] m_pc, m_ar, m_sp;
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  bit          skip = 1'b1;

  function automatic logic [7:0] rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [15:0] wd, output exp_t e);
    logic [15:0] a;
    e.lat = 2;
    case (op)
      OpFetch: begin a = m_pc; e.data = {rd(a + 16'd1), rd(a)}; m_pc = a + 16'd2; end
      OpRead:  begin a = m_ar; e.data = {rd(a + 16'd1), rd(a)}; end
      OpPop:   begin a = m_sp; e.data = {rd(a + 16'd1), rd(a)}; m_sp = a + 16'd2; end
      default: begin
        a = m_sp;
        ref_mem[a - 16'd1] = wd[15:8];
        ref_mem[a - 16'd2] = wd[7:0];
        m_sp   = a - 16'd2;
        e.data = wd;
        e.lat  = 3;
      end
    endcase
    e.pc = m_pc; e.ar = m_ar; e.sp = m_sp;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_regs(input logic [15:0] pc, input logic [15:0] ar, input logic [15:0] sp);
    @(negedge clk);
    ld_en = 1'b1; ld_pc = pc; ld_ar = ar; ld_sp = sp;
    m_pc = pc; m_ar = ar; m_sp = sp;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] wd, input bit hold,
                       input bit model);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_wdata = wd;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("req_ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    if (model) begin
      model_op(op, wd, e);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || !req_ready) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        return;
      end
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] edges [4];
    edges[0] = 16'hFFFF; edges[1] = 16'h0000; edges[2] = 16'hFFFE; edges[3] = 16'h0001;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_wdata = '0;
    m_pc = '0; m_ar = '0; m_sp = '0;
    fork
      begin : drv
        int bad;
        bit hold;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_idle", 64'({req_ready, rsp_valid, rsp_data, reg_sel, fun_sel, outd_sel,
                                mem_en, mem_wr, mem_data_out}),
            64'({1'b1, 1'b0, 16'h0, 3'b111, 3'b010, 2'b00, 1'b0, 1'b0, 8'h0}));
        skip = 1'b0;

        set_regs(16'h0100, 16'h2000, 16'h0300);
        poke(16'h0100, 8'h34); poke(16'h0101, 8'h12);
        poke(16'h2000, 8'hCD); poke(16'h2001, 8'hAB);
        issue(OpFetch, 16'h0, 1'b0, 1'b1);
        issue(OpRead,  16'h0, 1'b0, 1'b1);
        issue(OpPush,  16'hBEEF, 1'b0, 1'b1);
        issue(OpPop,   16'h0, 1'b0, 1'b1);
        drain();
        chk("push_hi_byte", 64'(mem_e[16'h02FF]), 64'h0BE);
        chk("push_lo_byte", 64'(mem_e[16'h02FE]), 64'h0EF);
        set_regs(16'hFFFF, 16'h2000, 16'h0300);
        poke(16'hFFFF, 8'h77); poke(16'h0000, 8'h66);
        issue(OpFetch, 16'h0, 1'b0, 1'b1);
        drain();
        chk("fetch_wrap_pc", 64'(pc_e), 64'h0001);

        for (int i = 0; i < 300; i++) begin
          if (i % 50 == 0) begin
            drain();
            set_regs(rnd_addr(), rnd_addr(), rnd_addr());
          end
          hold = ((i + 1) % 50 != 0) && ($urandom_range(0, 1) == 1);
          issue(2'($urandom), 16'($urandom), hold, 1'b1);
        end
        drain();

        // Reset while the first push byte is on the bus.
        skip = 1'b1;
        issue(OpPush, 16'h1357, 1'b0, 1'b0);
        bad = 0;
        while (!mem_wr && bad < 6) begin @(negedge clk); bad++; end
        chk("reach_push_b0", 64'(mem_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", 64'({req_ready, rsp_valid, rsp_data, reg_sel, mem_en, mem_wr}),
            64'({1'b1, 1'b0, 16'h0, 3'b111, 1'b0, 1'b0}));
        m_sp = m_sp - 16'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 64'(req_ready), 64'd1);
        chk("sp_after_midop_reset", 64'(sp_e), 64'(m_sp));
        skip = 1'b0;
        issue(OpPop, 16'h0, 1'b0, 1'b1);
        drain();

        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem_e[i] !== rd(16'(i))) bad++;
        chk("mem_image", 64'(bad), 64'd0);
        chk("final_pc", 64'(pc_e), 64'(m_pc));
        chk("final_ar", 64'(ar_e), 64'(m_ar));
        chk("final_sp", 64'(sp_e), 64'(m_sp));
      end
      begin : mon
        exp_t e;
        forever begin
          @(posedge clk);
          #1;
          cyc++;
          if (!skip) begin
            chk("bus_invariants",
                64'({$countones(~reg_sel) <= 1, !(mem_wr && !mem_en), mem_addr == arf_addr}),
                64'(3'b111));
            chk("ready_only_idle", 64'(req_ready), 64'(sb.size() == 0));
            if (rsp_valid) begin
              if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
              end else begin
                e = sb.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                chk("pc_after_op", 64'(pc_e), 64'(e.pc));
                chk("ar_after_op", 64'(ar_e), 64'(e.ar));
                chk("sp_after_op", 64'(sp_e), 64'(e.sp));
              end
            end
          end
        end
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
